sipu_seq: RTL

Parametrised sequencer for the simple image processor. It runs two passes over an IMG_W x IMG_H image held in memory. The first pass is a grayscale pass over the input memory. The second is an optional per-pixel quantisation pass on the output memory, either threshold-only or Floyd-Steinberg error diffusion. It drives the input memory, the grayscale unit, the output memory, the write-back mux and the error-diffusion unit, and replaces the fixed-size, free-running controller with a start/done handshake and a runtime mode.

---
 rtl/sipu_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sipu_seq.sv
// sipu_seq: two-pass sequencer for the simple image processor. It runs a grayscale pass, then an optional threshold or Floyd-Steinberg pass. Build with SIPU_THRESH_EN to get the threshold pass; without it, mode 1 runs as gray-only.
// Latency: 3 cycles/pixel gray, 2k+4 cycles/pixel FS (k = present neighbours), 4 cycles/pixel threshold; done one cycle after the last WB/NEXT.
// Backpressure: none. start is sampled only in IDLE. Every memory/unit strobe is a single cycle, decoded from registered state.
module sipu_seq #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic          in_mem_en,
    output logic [AW-1:0] in_mem_addr,
    output logic          gray_en,
    output logic          out_mem_en,
    output logic          out_mem_rd,
    output logic          out_mem_wr,
    output logic [AW-1:0] out_mem_addr,
    output logic          mux_sel,
    output logic          err_en,
    output logic [2:0]    err_sel
);

    typedef enum logic [4:0] {
        S_IDLE, S_LOAD, S_GRAY, S_WB,
        S_RD_C, S_RD_R, S_RD_LR, S_RD_LC, S_RD_LL,
        S_ERR,
        S_WR_R, S_WR_LR, S_WR_LC, S_WR_LL, S_WR_C,
        S_NEXT, S_DONE
    } state_t;

    localparam logic [AW-1:0] W_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 1);
    localparam logic [AW-1:0] P_LAST = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] ONE    = AW'(1);

    localparam logic [2:0] SL_C  = 3'd0;
    localparam logic [2:0] SL_R  = 3'd1;
    localparam logic [2:0] SL_LL = 3'd2;
    localparam logic [2:0] SL_LC = 3'd3;
    localparam logic [2:0] SL_LR = 3'd4;

    state_t        state_q, state_d;
    logic [AW-1:0] p_q, x_q, y_q, b_q;
    logic [1:0]    mode_q;
    logic          thr_mode, gray_only;
    logic          has_r, has_lr, has_lc, has_ll;
    logic [AW-1:0] addr_c, addr_r, addr_lc, addr_lr, addr_ll;

`ifdef SIPU_THRESH_EN
    assign thr_mode  = (mode_q == 2'd1);
    assign gray_only = (mode_q == 2'd0);
`else
    assign thr_mode  = 1'b0;
    assign gray_only = (mode_q == 2'd0) | (mode_q == 2'd1);
`endif

    // Threshold mode treats every neighbour as absent, so only the centre pixel is touched
    assign has_r  = !thr_mode && (x_q != X_LAST);
    assign has_lc = !thr_mode && (y_q != Y_LAST);
    assign has_lr = has_r && has_lc;
    assign has_ll = has_lc && (x_q != '0);

    // Row base b tracks y*IMG_W incrementally, so no multiplier is needed
    assign addr_c  = b_q + x_q;
    assign addr_r  = addr_c + ONE;
    assign addr_lc = addr_c + W_STEP;
    assign addr_lr = addr_lc + ONE;
    assign addr_ll = addr_lc - ONE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Pixel/column/row counters and the mode latched at start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            b_q    <= '0;
            mode_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    p_q    <= '0;
                    x_q    <= '0;
                    y_q    <= '0;
                    b_q    <= '0;
                    mode_q <= mode;
                end
                S_WB: if (p_q != P_LAST) p_q <= p_q + ONE;
                S_NEXT: begin
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        y_q <= y_q + ONE;
                        b_q <= b_q + W_STEP;
                    end else begin
                        x_q <= x_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state walk (absent neighbours skipped) and output decode from the registered state
    always_comb begin
        state_d      = state_q;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        in_mem_en    = 1'b0;
        in_mem_addr  = '0;
        gray_en      = 1'b0;
        out_mem_en   = 1'b0;
        out_mem_rd   = 1'b0;
        out_mem_wr   = 1'b0;
        out_mem_addr = '0;
        mux_sel      = 1'b0;
        err_en       = 1'b0;
        err_sel      = SL_C;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                in_mem_en   = 1'b1;
                in_mem_addr = p_q;
                state_d     = S_GRAY;
            end
            S_GRAY: begin
                gray_en = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                out_mem_en   = 1'b1;
                out_mem_wr   = 1'b1;
                out_mem_addr = p_q;
                if (p_q != P_LAST)  state_d = S_LOAD;
                else if (gray_only) state_d = S_DONE;
                else                state_d = S_RD_C;
            end
            S_RD_C, S_RD_R, S_RD_LR, S_RD_LC, S_RD_LL: begin
                out_mem_en = 1'b1;
                out_mem_rd = 1'b1;
                case (state_q)
                    S_RD_C:  begin out_mem_addr = addr_c;  err_sel = SL_C;  end
                    S_RD_R:  begin out_mem_addr = addr_r;  err_sel = SL_R;  end
                    S_RD_LR: begin out_mem_addr = addr_lr; err_sel = SL_LR; end
                    S_RD_LC: begin out_mem_addr = addr_lc; err_sel = SL_LC; end
                    default: begin out_mem_addr = addr_ll; err_sel = SL_LL; end
                endcase
                if      (state_q == S_RD_C && has_r)                        state_d = S_RD_R;
                else if ((state_q == S_RD_C || state_q == S_RD_R) && has_lr) state_d = S_RD_LR;
                else if (state_q != S_RD_LC && state_q != S_RD_LL && has_lc) state_d = S_RD_LC;
                else if (state_q != S_RD_LL && has_ll)                       state_d = S_RD_LL;
                else                                                         state_d = S_ERR;
            end
            S_ERR: begin
                err_en = 1'b1;
                if      (has_r)  state_d = S_WR_R;
                else if (has_lr) state_d = S_WR_LR;
                else if (has_lc) state_d = S_WR_LC;
                else if (has_ll) state_d = S_WR_LL;
                else             state_d = S_WR_C;
            end
            S_WR_R, S_WR_LR, S_WR_LC, S_WR_LL, S_WR_C: begin
                out_mem_en = 1'b1;
                out_mem_wr = 1'b1;
                mux_sel    = 1'b1;
                case (state_q)
                    S_WR_R:  begin out_mem_addr = addr_r;  err_sel = SL_R;  end
                    S_WR_LR: begin out_mem_addr = addr_lr; err_sel = SL_LR; end
                    S_WR_LC: begin out_mem_addr = addr_lc; err_sel = SL_LC; end
                    S_WR_LL: begin out_mem_addr = addr_ll; err_sel = SL_LL; end
                    default: begin out_mem_addr = addr_c;  err_sel = SL_C;  end
                endcase
                if      (state_q == S_WR_C)                                 state_d = S_NEXT;
                else if (state_q == S_WR_R && has_lr)                       state_d = S_WR_LR;
                else if ((state_q == S_WR_R || state_q == S_WR_LR) && has_lc) state_d = S_WR_LC;
                else if (state_q != S_WR_LL && has_ll)                      state_d = S_WR_LL;
                else                                                        state_d = S_WR_C;
            end
            S_NEXT: begin
                if (x_q == X_LAST && y_q == Y_LAST) state_d = S_DONE;
                else                                state_d = S_RD_C;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
